// File: rtl/ibuf_pkg.sv
// Shared widths and packed-entry layout for the dual-issue instruction buffer.
// Entry layout from MSB to LSB: {inst, pc, pred_addr, exc, cause}.
package ibuf_pkg;

    localparam int EXC_CAUSE_W = 7;
    localparam int INST_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int ENTRY_W     = INST_W + 2*ADDR_W + 1 + EXC_CAUSE_W;

    localparam int CAUSE_LSB = 0;
    localparam int EXC_BIT   = CAUSE_LSB + EXC_CAUSE_W;
    localparam int PRED_LSB  = EXC_BIT + 1;
    localparam int PC_LSB    = PRED_LSB + ADDR_W;
    localparam int INST_LSB  = PC_LSB + ADDR_W;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [INST_W-1:0]      inst,
        input logic [ADDR_W-1:0]      pc,
        input logic [ADDR_W-1:0]      pred_addr,
        input logic                   exc,
        input logic [EXC_CAUSE_W-1:0] cause
    );
        return {inst, pc, pred_addr, exc, cause};
    endfunction

endpackage

// File: rtl/ibuf_entry_ram.sv
// DEPTH x ENTRY_W register array: paired writes at waddr/waddr+1, paired
// asynchronous reads at raddr/raddr+1, synchronous active-low clear.
module ibuf_entry_ram
    import ibuf_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata0_i,
    input  logic [ENTRY_W-1:0] wdata1_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata0_o,
    output logic [ENTRY_W-1:0] rdata1_o
);

    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   waddr1;
    logic [PTR_W-1:0]   raddr1;

    // +1 wraps modulo DEPTH because DEPTH is a power of two
    assign waddr1 = waddr_i + ONE;
    assign raddr1 = raddr_i + ONE;

    assign rdata0_o = mem_q[raddr_i];
    assign rdata1_o = mem_q[raddr1];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata0_i;
            mem_q[waddr1]  <= wdata1_i;
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction queue between icache fetch and decode.
// Optional IBUF_PERF_CNT_EN adds stall / empty cycle counters.
module inst_buffer
    import ibuf_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [INST_W-1:0]      in_inst1,
    input  logic [INST_W-1:0]      in_inst2,
    input  logic [ADDR_W-1:0]      in_pc1,
    input  logic [ADDR_W-1:0]      in_pc2,
    input  logic [ADDR_W-1:0]      in_pred_addr,
    input  logic                   in_is_exception,
    input  logic [EXC_CAUSE_W-1:0] in_exception_cause,
    output logic                   ibuf_stall,
    input  logic                   dec_ready1,
    input  logic                   dec_ready2,
    output logic                   out_valid1,
    output logic                   out_valid2,
    output logic [INST_W-1:0]      out_inst1,
    output logic [INST_W-1:0]      out_inst2,
    output logic [ADDR_W-1:0]      out_pc1,
    output logic [ADDR_W-1:0]      out_pc2,
    output logic [ADDR_W-1:0]      out_pred_addr1,
    output logic [ADDR_W-1:0]      out_pred_addr2,
    output logic                   out_is_exception1,
    output logic                   out_is_exception2,
    output logic [EXC_CAUSE_W-1:0] out_exception_cause1,
    output logic [EXC_CAUSE_W-1:0] out_exception_cause2
`ifdef IBUF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_empty_cycles
`endif
);

    localparam logic [PTR_W:0]   STALL_TH = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               enq, pop1, pop2;
    logic [ENTRY_W-1:0] wdata0, wdata1;
    logic [ENTRY_W-1:0] rdata0, rdata1;

    // Stall looks at registered occupancy only; a same-cycle pop gives no credit
    assign ibuf_stall = (count_q > STALL_TH);
    assign out_valid1 = (count_q != '0);
    assign out_valid2 = (count_q >= CNT_TWO);

    assign enq  = in_valid & ~ibuf_stall;
    assign pop1 = out_valid1 & dec_ready1;
    assign pop2 = pop1 & out_valid2 & dec_ready2;

    always_comb begin
        head_d  = head_q + PTR_W'(pop1) + PTR_W'(pop2);
        tail_d  = enq ? (tail_q + PTR_TWO) : tail_q;
        count_d = count_q + (enq ? CNT_TWO : '0) - (PTR_W+1)'(pop1) - (PTR_W+1)'(pop2);
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wdata0 = pack_entry(in_inst1, in_pc1, in_pred_addr, in_is_exception, in_exception_cause);
    assign wdata1 = pack_entry(in_inst2, in_pc2, in_pred_addr, in_is_exception, in_exception_cause);

    // A flush discards the enqueue but leaves stored entries untouched
    ibuf_entry_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i    (clk),
        .rst_n_i  (rst),
        .we_i     (enq & ~flush),
        .waddr_i  (tail_q),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr_i  (head_q),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    assign out_inst1            = rdata0[INST_LSB +: INST_W];
    assign out_inst2            = rdata1[INST_LSB +: INST_W];
    assign out_pc1              = rdata0[PC_LSB +: ADDR_W];
    assign out_pc2              = rdata1[PC_LSB +: ADDR_W];
    assign out_pred_addr1       = rdata0[PRED_LSB +: ADDR_W];
    assign out_pred_addr2       = rdata1[PRED_LSB +: ADDR_W];
    assign out_is_exception1    = rdata0[EXC_BIT];
    assign out_is_exception2    = rdata1[EXC_BIT];
    assign out_exception_cause1 = rdata0[CAUSE_LSB +: EXC_CAUSE_W];
    assign out_exception_cause2 = rdata1[CAUSE_LSB +: EXC_CAUSE_W];

`ifdef IBUF_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_empty_q;

    // Cleared only by reset so that flushes do not lose history
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_empty_q <= '0;
        end else begin
            if (ibuf_stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (count_q == '0) perf_empty_q <= perf_empty_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=8); also covers IBUF_PERF_CNT_EN when defined.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst1, in_inst2, in_pc1, in_pc2, in_pred_addr;
    logic        in_is_exception;
    logic [6:0]  in_exception_cause;
    logic        ibuf_stall;
    logic        dec_ready1, dec_ready2;
    logic        out_valid1, out_valid2;
    logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2, out_pred_addr1, out_pred_addr2;
    logic        out_is_exception1, out_is_exception2;
    logic [6:0]  out_exception_cause1, out_exception_cause2;
`ifdef IBUF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_empty_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_inst1             (in_inst1),
        .in_inst2             (in_inst2),
        .in_pc1               (in_pc1),
        .in_pc2               (in_pc2),
        .in_pred_addr         (in_pred_addr),
        .in_is_exception      (in_is_exception),
        .in_exception_cause   (in_exception_cause),
        .ibuf_stall           (ibuf_stall),
        .dec_ready1           (dec_ready1),
        .dec_ready2           (dec_ready2),
        .out_valid1           (out_valid1),
        .out_valid2           (out_valid2),
        .out_inst1            (out_inst1),
        .out_inst2            (out_inst2),
        .out_pc1              (out_pc1),
        .out_pc2              (out_pc2),
        .out_pred_addr1       (out_pred_addr1),
        .out_pred_addr2       (out_pred_addr2),
        .out_is_exception1    (out_is_exception1),
        .out_is_exception2    (out_is_exception2),
        .out_exception_cause1 (out_exception_cause1),
        .out_exception_cause2 (out_exception_cause2)
`ifdef IBUF_PERF_CNT_EN
        ,
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_empty_cycles    (perf_empty_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2);
        in_valid = 1'b1;
        in_pc1   = pc;
        in_pc2   = pc + 32'd4;
        in_inst1 = i1;
        in_inst2 = i2;
        step();
        in_valid = 1'b0;
    endtask

    // Pops with dec_ready=11 until empty; returns number of entries and last PC seen
    task automatic drain(output int n, output logic [31:0] last_pc);
        n = 0;
        last_pc = '0;
        for (int k = 0; k < 20 && out_valid1; k++) begin
            n++;
            last_pc = out_pc1;
            if (out_valid2) begin
                n++;
                last_pc = out_pc2;
            end
            dec_ready1 = 1'b1;
            dec_ready2 = 1'b1;
            step();
        end
        dec_ready1 = 1'b0;
        dec_ready2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc, last_pc;
        int          n;
`ifdef IBUF_PERF_CNT_EN
        logic [31:0] snap;
`endif
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_inst1 = '0; in_inst2 = '0; in_pc1 = '0; in_pc2 = '0; in_pred_addr = '0;
        in_is_exception = 1'b0; in_exception_cause = '0;
        dec_ready1 = 1'b0; dec_ready2 = 1'b0;
        step(); step();
        rst = 1'b1;

        check("rst_valid1", out_valid1, 0);
        check("rst_valid2", out_valid2, 0);
        check("rst_stall", ibuf_stall, 0);
        check("rst_pc1", out_pc1, 0);
        check("rst_inst2", out_inst2, 0);
        check("rst_pred1", out_pred_addr1, 0);

        // Single packet, visible the cycle after the enqueue edge
        send_pkt(32'h1c000000, 32'h11, 32'h22);
        check("one_valid1", out_valid1, 1);
        check("one_valid2", out_valid2, 1);
        check("one_pc1", out_pc1, 32'h1c000000);
        check("one_pc2", out_pc2, 32'h1c000004);
        check("one_inst1", out_inst1, 32'h11);
        check("one_inst2", out_inst2, 32'h22);
        check("one_stall", ibuf_stall, 0);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush1_valid1", out_valid1, 0);

        // Fill to full: stall only once count exceeds DEPTH-2
        for (int k = 0; k < 4; k++) begin
            send_pkt(32'h1c000000 + 32'(8*k), 32'(2*k+1), 32'(2*k+2));
            if (k == 2) check("fill3_stall", ibuf_stall, 0);
            if (k == 3) check("fill4_stall", ibuf_stall, 1);
        end
        send_pkt(32'hdead0000, 32'hdead, 32'hbeef);
        check("ignored_stall", ibuf_stall, 1);
        check("ignored_pc1", out_pc1, 32'h1c000000);
        check("ignored_inst1", out_inst1, 32'h1);

        // Single pop to make head odd, then pop pairs across the wrap
        dec_ready1 = 1'b1; step(); dec_ready1 = 1'b0;
        check("pop1_pc1", out_pc1, 32'h1c000004);
        check("pop1_stall_cnt7", ibuf_stall, 1);
        dec_ready1 = 1'b1; dec_ready2 = 1'b1; step(); dec_ready1 = 1'b0; dec_ready2 = 1'b0;
        check("pop2_pc1", out_pc1, 32'h1c00000c);
        check("pop2_stall_cnt5", ibuf_stall, 0);
        send_pkt(32'h1c000020, 32'h9, 32'ha);
        check("wrap_stall_cnt7", ibuf_stall, 1);
        exp_pc = 32'h1c00000c;
        for (int k = 0; k < 10 && out_valid1; k++) begin
            check("wrap_pc1", out_pc1, exp_pc);
            if (out_valid2) check("wrap_pc2", out_pc2, exp_pc + 32'd4);
            exp_pc = exp_pc + (out_valid2 ? 32'd8 : 32'd4);
            dec_ready1 = 1'b1; dec_ready2 = 1'b1;
            step();
        end
        dec_ready1 = 1'b0; dec_ready2 = 1'b0;
        check("wrap_end_pc", exp_pc, 32'h1c000028);
        check("wrap_empty", out_valid1, 0);

        // Enqueue and dual pop in the same cycle at count 6
        for (int k = 0; k < 3; k++) send_pkt(32'h1c000100 + 32'(8*k), 32'h100 + 32'(k), 32'h200 + 32'(k));
        check("conc_pre_stall", ibuf_stall, 0);
        dec_ready1 = 1'b1; dec_ready2 = 1'b1;
        send_pkt(32'h1c000118, 32'h103, 32'h203);
        dec_ready1 = 1'b0; dec_ready2 = 1'b0;
        check("conc_stall", ibuf_stall, 0);
        check("conc_pc1", out_pc1, 32'h1c000108);
        drain(n, last_pc);
        check("conc_count", 64'(n), 6);
        check("conc_last_pc", last_pc, 32'h1c00011c);

        // Flush beats a simultaneous enqueue and dequeue
        for (int k = 0; k < 3; k++) send_pkt(32'h1c000200 + 32'(8*k), 32'h300, 32'h301);
        dec_ready1 = 1'b1; step(); dec_ready1 = 1'b0;
        check("pre_flush_valid2", out_valid2, 1);
        flush = 1'b1; dec_ready1 = 1'b1; dec_ready2 = 1'b1;
        send_pkt(32'h1c000300, 32'h400, 32'h401);
        flush = 1'b0; dec_ready1 = 1'b0; dec_ready2 = 1'b0;
        check("flush_valid1", out_valid1, 0);
        check("flush_valid2", out_valid2, 0);
        check("flush_stall", ibuf_stall, 0);
        step();
        check("flush_noenq", out_valid1, 0);

        // Exception info is replicated into both entries of the packet
        in_is_exception = 1'b1; in_exception_cause = 7'h08; in_pred_addr = 32'h1c001000;
        send_pkt(32'h1c000400, 32'h500, 32'h501);
        in_is_exception = 1'b0; in_exception_cause = '0;
        check("exc1", out_is_exception1, 1);
        check("exc2", out_is_exception2, 1);
        check("cause1", out_exception_cause1, 7'h08);
        check("cause2", out_exception_cause2, 7'h08);
        check("pred1", out_pred_addr1, 32'h1c001000);
        check("pred2", out_pred_addr2, 32'h1c001000);

`ifdef IBUF_PERF_CNT_EN
        flush = 1'b1; step(); flush = 1'b0;
        snap = perf_empty_cycles;
        step(); step(); step();
        check("perf_empty_delta", perf_empty_cycles - snap, 3);
        for (int k = 0; k < 4; k++) send_pkt(32'h1c000500 + 32'(8*k), 32'h0, 32'h0);
        snap = perf_stall_cycles;
        for (int k = 0; k < 10; k++) step();
        check("perf_stall_delta", perf_stall_cycles - snap, 10);
`endif

        // Mid-operation reset overrides pending traffic
        in_valid = 1'b1; dec_ready1 = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; in_valid = 1'b0; dec_ready1 = 1'b0;
        check("rst2_valid1", out_valid1, 0);
        check("rst2_pc1", out_pc1, 0);
`ifdef IBUF_PERF_CNT_EN
        check("rst2_perf_stall", perf_stall_cycles, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-issue instruction queue between the icache fetch stage (upstream) and the decoder (downstream).
- Each cycle it accepts one fetch packet from the icache: two sequential instructions with their PCs, the predicted address and exception info.
- It presents the two oldest instructions to the decoder.
- It absorbs decoder back-pressure and raises a stall toward the fetch side when fewer than two slots are free.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets the block
- flush  in  1  pipeline flush (branch mispredict or exception redirect)
- in_valid  in  1  fetch packet valid (icache inst_valid)
- in_inst1  in  32  first instruction
- in_inst2  in  32  second instruction
- in_pc1  in  32  PC of first instruction
- in_pc2  in  32  PC of second instruction
- in_pred_addr  in  32  predicted next fetch address for the packet
- in_is_exception  in  1  fetch exception for the packet
- in_exception_cause  in  7  exception cause code
- ibuf_stall  out  1  buffer cannot take a packet; fetch must hold
- out_valid1 / out_valid2  out  1 each  head / head+1 entries valid
- out_inst1 / out_inst2  out  32 each  instructions
- out_pc1 / out_pc2  out  32 each  PCs
- out_pred_addr1 / out_pred_addr2  out  32 each  predicted address stored with the entry
- out_is_exception1 / out_is_exception2  out  1 each  exception flag per entry
- out_exception_cause1 / out_exception_cause2  out  7 each  cause per entry
- dec_ready1  in  1  decoder consumes slot 1 this cycle
- dec_ready2  in  1  decoder consumes slot 2; only effective together with dec_ready1

Behaviour:
- State:
  - head pointer and tail pointer (PTR_W bits, wrap modulo DEPTH)
  - count, PTR_W+1 bits
  - entry array of {inst, pc, pred_addr, exc, cause}
- Enqueue:
  - enq = in_valid & !ibuf_stall.
  - On enq, entries tail and tail+1 are written with packet words 1 and 2.
  - pred_addr, is_exception and cause are copied into both entries.
  - tail advances by 2.
  - in_valid while stalled is ignored; upstream holds the packet.
- ibuf_stall = (count > DEPTH-2). It is computed from registered count only; there is no same-cycle credit from a dequeue.
- Outputs are read combinationally from entries head and head+1:
  - out_valid1 = (count >= 1)
  - out_valid2 = (count >= 2)
  - Data on invalid slots is don't-care, but must not be X after reset; entry storage resets to 0.
- Dequeue:
  - pop1 = out_valid1 & dec_ready1
  - pop2 = pop1 & out_valid2 & dec_ready2
  - head advances by pop1+pop2.
- Count update: count_next = count + (enq?2:0) - pop1 - pop2. Simultaneous enq and pop in one cycle is legal.
- Latency: a packet enqueued at edge N is visible on the outputs after edge N (available to the decoder in cycle N+1). There is no bypass.
- Priority at an edge is reset (rst==0), then flush, then normal operation.
  - Reset: head=tail=count=0, all entries cleared.
  - Flush: head=tail=count=0; any enqueue and dequeue in that cycle are discarded; entry contents are untouched.
- Reset asserted mid-operation takes effect at the next edge regardless of in_valid or dec_ready.
- Output values after reset:
  - out_valid1 = out_valid2 = 0
  - ibuf_stall = 0
  - all data outputs = 0
- Wrap-around: pointers wrap naturally. Since DEPTH is even and enqueue is always 2, tail is always even. Head may be odd; head+1 wraps via modulo.
- Full boundary: count==DEPTH-1 or DEPTH gives stall=1. count==DEPTH-2 gives stall=0.

Optional Feature:
- Macro: IBUF_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_stall_cycles[31:0] and perf_empty_cycles[31:0].
  - perf_stall_cycles increments on every cycle where ibuf_stall=1.
  - perf_empty_cycles increments on every cycle where count==0 and rst==1.
  - Both counters are cleared by reset, not by flush, and wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package ibuf_pkg holds:
  - EXC_CAUSE_W=7, INST_W=32, ADDR_W=32
  - ENTRY_W = INST_W+2*ADDR_W+1+EXC_CAUSE_W
  - field offset constants for the packed entry
- One sub-module, ibuf_entry_ram:
  - DEPTH x ENTRY_W register array
  - 2 write ports at tail and tail+1
  - 2 asynchronous read ports at head and head+1
  - synchronous active-low clear

Test Plan:
- Reset, then one packet (pc1=0x1c000000, pc2=0x1c000004, inst 0x11/0x22) with dec_ready=00 → next cycle out_valid=11, out_pc1=0x1c000000, out_inst2=0x22, ibuf_stall=0.
- Fill with DEPTH=8, 4 packets, dec_ready=00 → after the 3rd packet count=6, stall=0; after the 4th count=8, stall=1; a 5th in_valid is ignored and count stays 8.
- Odd-head wrap: fill 8, then dec_ready1 only for 1 cycle (count=7, head=1), then dec_ready=11 repeatedly → PCs emerge in order 0x..04, 0x..08, ... across index 7→0 with no gap or duplicate.
- Concurrent: count=6, in_valid=1 and dec_ready=11 in the same cycle → packet accepted, 2 popped, count stays 6.
- Flush with count=5, in_valid=1 and dec_ready=11 → next cycle out_valid=00, count=0, stall=0; nothing enqueued.
- Exception packet (in_is_exception=1, cause=7'h08) → both entries show exc=1, cause=0x08; with IBUF_PERF_CNT_EN, 10 full cycles give perf_stall_cycles=10.
